inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch unit: the producer feeding i_inst_data of the RV32 instruction decoder.
//  Keeps the PC and issues in-order word reads to instruction memory (req/gnt, in-order rvalid).
//  Buffers returned words in a small FIFO and presents them downstream with valid/ready.
//  Branch/jump redirects flush the FIFO and discard stale in-flight responses.
// PARAMETERS
//  ADDR_W      32    PC / memory address width
//  DEPTH       4     FIFO entries; also the max in-flight requests + buffered words (2..8)
//  RESET_PC    0     first fetch address after reset (4-byte aligned)
// PORTS
//  i_clk           in   1       clock, all logic on rising edge
//  i_rst_n         in   1       reset, asynchronous assert, active-low
//  o_imem_req      out  1       memory read request
//  o_imem_addr     out  ADDR_W  request address, bits [1:0] always 00
//  i_imem_gnt      in   1       request accepted this cycle (only meaningful with o_imem_req)
//  i_imem_rvalid   in   1       read data valid; responses return in request order, >=1 cycle after gnt
//  i_imem_rdata    in   32      read data
//  o_inst_valid    out  1       o_inst_data/o_inst_pc hold a fetched instruction
//  i_inst_ready    in   1       downstream consumes the instruction this cycle
//  o_inst_data     out  32      instruction word; 32'h00000013 (NOP) when FIFO empty
//  o_inst_pc       out  ADDR_W  address of o_inst_data; 0 when FIFO empty
//  i_redirect      in   1       branch/jump taken: restart fetch
//  i_redirect_pc   in   ADDR_W  new fetch address; bits [1:0] ignored (forced 00)
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low (i_clk, i_rst_n).
//  Reset: state=BOOT, fetch_pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0; outputs o_imem_req=0,
//   o_imem_addr=RESET_PC, o_inst_valid=0, o_inst_data=32'h00000013, o_inst_pc=0.
//  FSM: BOOT -> RUN unconditionally one cycle after reset release; RUN stays until reset.
//   Reset asserted mid-operation returns to BOOT at once; in-flight responses are then the memory's problem.
//  Issue (RUN only): o_imem_req = (inflight + fifo_count < DEPTH) && !i_redirect; o_imem_addr = fetch_pc.
//   On req&&gnt: fetch_pc += 4 (wraps mod 2^ADDR_W), inflight++. req stays asserted and addr stable until gnt.
//  Response: on i_imem_rvalid, inflight--. If drop_cnt>0: word discarded, drop_cnt--.
//   Else word and its PC (from an internal response-PC counter) pushed into FIFO; visible next cycle.
//  Credit rule guarantees no overflow: a response with FIFO full is impossible; assert in simulation.
//  Output: o_inst_valid = (fifo_count>0) && !i_redirect; head entry drives o_inst_data/o_inst_pc.
//   Pop on o_inst_valid && i_inst_ready; push and pop in same cycle allowed, count unchanged.
//   Data/pc must hold stable while valid && !ready.
//  Redirect (any cycle in RUN): FIFO cleared, fetch_pc = response-PC counter base = {i_redirect_pc[ADDR_W-1:2],2'b00},
//   drop_cnt = inflight after this cycle's updates (includes a request granted this cycle is impossible since
//   req is 0; excludes a response returned this cycle, which is itself dropped). No pop occurs.
//   New requests issue from the next cycle without waiting for drop_cnt to reach 0 (in-order return).
//  Redirect while drop_cnt>0: drop_cnt re-computed the same way (all still in-flight requests dropped).
//  Redirect in BOOT: fetch_pc updated; no other effect.
//  Latency (zero-wait memory, gnt same cycle, rvalid next cycle): request at cycle N -> o_inst_valid at N+2.
//  Throughput: one instruction per cycle with single-cycle memory and i_inst_ready held high.
// TESTING
//  Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> addrs 0,4,8.. one per cycle; pc/data stream in order.
//  Hold i_inst_ready=0 with DEPTH=4 -> exactly 4 grants then o_imem_req=0; data stable; resume -> no loss/dup.
//  gnt low 3 cycles on addr 0x10 -> o_imem_req=1 and o_imem_addr=0x10 held; fetch_pc not advanced.
//  Redirect to 0x103 with 2 requests in flight -> next addr 0x100; both stale words dropped; first valid pc=0x100.
//  Redirect in same cycle as rvalid and as ready pop -> o_inst_valid=0 that cycle, word dropped, FIFO empty next.
//  fetch_pc = 2^ADDR_W-4 -> next request address 0; reset asserted mid-stream -> all outputs at reset values at once.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC generation, credit-limited in-order memory reads,
// response FIFO with valid/ready output and redirect flush with stale-response drop.
module inst_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [31:0]       i_imem_rdata,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [31:0]       o_inst_data,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc
);

    localparam int unsigned     CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned     PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [0:0]      ST_BOOT  = 1'b0;
    localparam logic [0:0]      ST_RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]       fifo_data_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q [DEPTH];

    logic              run, gnt_fire, rsp, drop, push, pop;
    logic [CNT_W:0]    credit;
    logic [ADDR_W-1:0] redirect_pc_al;

    assign run            = (state_q == ST_RUN);
    assign credit         = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign redirect_pc_al = {i_redirect_pc[ADDR_W-1:2], 2'b00};

    assign o_imem_req   = run && (credit < {1'b0, DEPTH_C}) && !i_redirect;
    assign o_imem_addr  = fetch_pc_q;
    assign o_inst_valid = (fifo_cnt_q != '0) && !i_redirect;
    assign o_inst_data  = (fifo_cnt_q != '0) ? fifo_data_q[rd_ptr_q] : NOP;
    assign o_inst_pc    = (fifo_cnt_q != '0) ? fifo_pc_q[rd_ptr_q] : '0;

    assign gnt_fire = o_imem_req && i_imem_gnt;
    assign rsp      = run && i_imem_rvalid;
    assign drop     = rsp && (drop_cnt_q != '0);
    // A response arriving with a redirect belongs to the old stream and is dropped too.
    assign push     = rsp && !drop && !i_redirect;
    assign pop      = o_inst_valid && i_inst_ready;

    always_comb begin
        state_d    = ST_RUN;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            inflight_d = inflight_d + CNT_W'(1);
        end
        if (rsp) begin
            inflight_d = inflight_d - CNT_W'(1);
        end
        if (drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
        if (push) begin
            wr_ptr_d  = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            resp_pc_d = resp_pc_q + ADDR_W'(4);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end

        if (i_redirect) begin
            fetch_pc_d = redirect_pc_al;
            resp_pc_d  = redirect_pc_al;
            if (run) begin
                fifo_cnt_d = '0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                drop_cnt_d = inflight_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= i_imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    // Credits cover every in-flight request, so a full FIFO can never receive a word.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        push |-> (fifo_cnt_q != DEPTH_C));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: in-order memory model, consumer-side stream
// scoreboard and hand-computed checks of issue, backpressure, redirect and reset.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, inst_ready, redirect;
    logic [31:0] inst_data, inst_pc, redirect_pc;

    bit          rsp_en, chk_en;
    int          n_checks = 0;
    int          n_errors = 0;
    int          pops, grants;
    logic [31:0] exp_pc;
    logic [31:0] pending [$];
    logic        cap_req, cap_valid;
    logic [31:0] cap_addr, cap_data, cap_pc;

    inst_fetch #(
        .ADDR_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_inst_valid  (inst_valid),
        .i_inst_ready  (inst_ready),
        .o_inst_data   (inst_data),
        .o_inst_pc     (inst_pc),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge; caller sets inputs beforehand.
    task automatic cyc();
        if (rsp_en && pending.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pending.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        cap_req   = imem_req;
        cap_addr  = imem_addr;
        cap_valid = inst_valid;
        cap_data  = inst_data;
        cap_pc    = inst_pc;
        if (imem_req && imem_gnt) begin
            pending.push_back(imem_addr);
            grants++;
        end
        if (chk_en && inst_valid && inst_ready) begin
            check("stream_pc", inst_pc, exp_pc);
            check("stream_data", inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_data"}, inst_data, 32'h0000_0013);
        check({tag, "_pc"}, inst_pc, 32'h0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        rsp_en      = 1'b1;
        chk_en      = 1'b0;
        pops        = 0;
        grants      = 0;
        pending.delete();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Basic stream: one request per cycle, first instruction two cycles after first request.
        do_reset();
        cyc();
        check("boot_req", {31'b0, cap_req}, 32'd0);
        imem_gnt = 1'b1; inst_ready = 1'b1; chk_en = 1'b1; exp_pc = 32'h0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("run_req", {31'b0, cap_req}, 32'd1);
            check("run_addr", cap_addr, 32'(4 * k));
            check("run_valid", {31'b0, cap_valid}, (k < 2) ? 32'd0 : 32'd1);
        end
        check("run_pops", pops, 6);

        // Backpressure: exactly DEPTH grants, head held stable, then lossless resume.
        do_reset();
        cyc();
        imem_gnt = 1'b1; inst_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k >= 2) check("bp_hold_pc", cap_pc, 32'h0);
        end
        check("bp_grants", grants, 4);
        check("bp_req_off", {31'b0, cap_req}, 32'd0);
        check("bp_valid", {31'b0, cap_valid}, 32'd1);
        check("bp_data", cap_data, mem_word(32'h0));
        inst_ready = 1'b1; chk_en = 1'b1; exp_pc = 32'h0; pops = 0;
        repeat (10) cyc();
        check("bp_resume_pops", pops, 10);

        // Grant stall on 0x10: request and address held.
        do_reset();
        cyc();
        imem_gnt = 1'b1; inst_ready = 1'b1; chk_en = 1'b1; exp_pc = 32'h0;
        repeat (4) cyc();
        imem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall_req", {31'b0, cap_req}, 32'd1);
            check("stall_addr", cap_addr, 32'h10);
        end
        imem_gnt = 1'b1;
        cyc();
        check("stall_gnt_addr", cap_addr, 32'h10);
        cyc();
        check("stall_next_addr", cap_addr, 32'h14);
        repeat (3) cyc();

        // Redirect to 0x103 with two requests outstanding.
        do_reset();
        cyc();
        imem_gnt = 1'b1; inst_ready = 1'b1; rsp_en = 1'b0; chk_en = 1'b1; exp_pc = 32'h100;
        repeat (2) cyc();
        redirect = 1'b1; redirect_pc = 32'h103;
        cyc();
        check("redir_req", {31'b0, cap_req}, 32'd0);
        check("redir_valid", {31'b0, cap_valid}, 32'd0);
        redirect = 1'b0; rsp_en = 1'b1;
        cyc();
        check("redir_addr0", cap_addr, 32'h100);
        check("redir_drop0", {31'b0, cap_valid}, 32'd0);
        cyc();
        check("redir_addr1", cap_addr, 32'h104);
        check("redir_drop1", {31'b0, cap_valid}, 32'd0);
        cyc();
        check("redir_empty", {31'b0, cap_valid}, 32'd0);
        cyc();
        check("redir_first_valid", {31'b0, cap_valid}, 32'd1);
        check("redir_first_pc", cap_pc, 32'h100);
        repeat (2) cyc();

        // Redirect coinciding with a response and a ready consumer.
        redirect = 1'b1; redirect_pc = 32'h200; exp_pc = 32'h200;
        cyc();
        check("rr_rvalid_seen", {31'b0, cap_valid}, 32'd0);
        redirect = 1'b0;
        cyc();
        check("rr_after_valid", {31'b0, cap_valid}, 32'd0);
        check("rr_after_data", cap_data, 32'h0000_0013);
        check("rr_after_pc", cap_pc, 32'h0);
        cyc();
        cyc();
        check("rr_new_valid", {31'b0, cap_valid}, 32'd1);
        check("rr_new_pc", cap_pc, 32'h200);

        // Redirect during boot, then address wrap.
        do_reset();
        imem_gnt = 1'b1; inst_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        cyc();
        check("boot_redir_req", {31'b0, cap_req}, 32'd0);
        redirect = 1'b0; chk_en = 1'b1; exp_pc = 32'hFFFF_FFF8;
        cyc();
        check("wrap_addr0", cap_addr, 32'hFFFF_FFF8);
        cyc();
        check("wrap_addr1", cap_addr, 32'hFFFF_FFFC);
        cyc();
        check("wrap_addr2", cap_addr, 32'h0000_0000);
        cyc();
        check("wrap_addr3", cap_addr, 32'h0000_0004);
        check("wrap_pops", pops, 2);

        // Asynchronous reset in the middle of a stream.
        #1;
        check("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        pending.delete();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
